// File: rtl/scramble_sequencer.sv
// scramble_sequencer: drives the 4x4 grid select/fire lines, passing user moves through
// in IDLE and issuing NUM_MOVES spaced pseudo-random fires on a scramble request.
module scramble_sequencer #(
   parameter int NUM_MOVES = 16,
   parameter int MOVE_GAP  = 16,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       rand_in,
   input  logic [3:0]       user_row_column,
   input  logic             user_nRow,
   input  logic             user_fire,
   input  logic             user_error,
   output logic [3:0]       row_column,
   output logic             x_nRow,
   output logic             fire,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] moves_left
);
   typedef enum logic [2:0] {IDLE, LOAD, FIRE, GAP, DONE} state_t;
   localparam logic [CNT_W-1:0] MOVES_LD = CNT_W'(NUM_MOVES);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(MOVE_GAP > 2 ? MOVE_GAP - 3 : 0);
   state_t           state_q;
   logic [CNT_W-1:0] gap_q, moves_q;
   logic [2:0]       last_q;
   logic [3:0]       rc_q;
   logic             nrow_q, fire_q, busy_q, done_q;
   logic [1:0]       idx_d;
   // repeating the previous move would undo it, so bump the line index instead
   assign idx_d = rand_in[1:0] + 2'(rand_in == last_q);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         gap_q   <= '0;
         moves_q <= '0;
         last_q  <= '0;
         rc_q    <= '0;
         nrow_q  <= 1'b0;
         fire_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         fire_q <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            IDLE:
               if (start) begin
                  state_q <= LOAD;
                  busy_q  <= 1'b1;
                  moves_q <= MOVES_LD;
               end else begin
                  rc_q   <= user_row_column;
                  nrow_q <= user_nRow;
                  fire_q <= user_fire & ~user_error;
               end
            LOAD: begin
               rc_q    <= 4'b0001 << idx_d;
               nrow_q  <= rand_in[2];
               last_q  <= {rand_in[2], idx_d};
               fire_q  <= 1'b1;
               moves_q <= moves_q - CNT_W'(1);
               state_q <= FIRE;
            end
            FIRE, GAP:
               if (state_q == FIRE && MOVE_GAP > 2) begin
                  state_q <= GAP;
                  gap_q   <= GAP_LD;
               end else if (state_q == GAP && gap_q != '0) begin
                  gap_q <= gap_q - CNT_W'(1);
               end else if (moves_q == '0) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  rc_q    <= '0;
               end else begin
                  state_q <= LOAD;
               end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign row_column = rc_q;
   assign x_nRow     = nrow_q;
   assign fire       = fire_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign moves_left = moves_q;
endmodule

// File: tb/tb_scramble_sequencer.sv
// tb_scramble_sequencer: vector table for user pass-through plus randomized scrambles
// checked against a move-list model of the scramble timing and anti-repeat rule.
module tb_scramble_sequencer;
   localparam int N = 4;
   localparam int G = 8;
   localparam int L = N * G + 3;
   logic       clk = 1'b0;
   logic       reset, start, user_nRow, user_fire, user_error, x_nRow, fire, busy, done;
   logic [2:0] rand_in;
   logic [3:0] user_row_column, row_column;
   logic [7:0] moves_left;
   int         total = 0, bad = 0, last = 0;

   scramble_sequencer #(.NUM_MOVES(N), .MOVE_GAP(G), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .rand_in(rand_in),
      .user_row_column(user_row_column), .user_nRow(user_nRow), .user_fire(user_fire),
      .user_error(user_error), .row_column(row_column), .x_nRow(x_nRow), .fire(fire),
      .busy(busy), .done(done), .moves_left(moves_left)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] urc;
      logic       unr, uf, ue;
      logic [3:0] rc;
      logic       nr, f;
   } vec_t;
   vec_t vec[6];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Start cycle is the edge-0 sample; edge j outputs are sampled 1 time unit later.
   task automatic scramble(input bit hold101, input bit poke, input bit same_fire);
      int rin[L], rc_o[L], nr_o[L], f_o[L], ml_o[L], d_o[L], b_o[L];
      int mv_rc[N], mv_nr[N];
      for (int j = 0; j < L; j++) begin
         bit pk;
         @(negedge clk);
         pk = poke && (j == 5 || j == 12 || j == 20);
         start = (j == 0) || pk;
         user_fire = (same_fire && j == 0) || pk;
         user_row_column = (j == 0) ? 4'b1000 : 4'($urandom);
         user_nRow = 1'($urandom);
         user_error = 1'b0;
         rand_in = hold101 ? 3'b101 : 3'($urandom);
         @(posedge clk);
         rin[j] = int'(rand_in);
         #1;
         rc_o[j] = int'(row_column); nr_o[j] = int'(x_nRow); f_o[j] = int'(fire);
         ml_o[j] = int'(moves_left); d_o[j] = int'(done); b_o[j] = int'(busy);
      end
      @(negedge clk);
      start = 1'b0;
      user_fire = 1'b0;
      for (int m = 0; m < N; m++) begin
         int r, idx;
         r = rin[1 + m * G];
         idx = r % 4;
         if (r == last) idx = (idx + 1) % 4;
         last = (r / 4) * 4 + idx;
         mv_rc[m] = 1 << idx;
         mv_nr[m] = r / 4;
      end
      for (int j = 0; j < L; j++) begin
         int fires;
         fires = (j < 1) ? 0 : (((j - 1) / G + 1 > N) ? N : (j - 1) / G + 1);
         chk("sc_fire", f_o[j], (j >= 1 && (j - 1) % G == 0 && (j - 1) / G < N) ? 1 : 0);
         chk("sc_busy", b_o[j], (j <= N * G) ? 1 : 0);
         chk("sc_done", d_o[j], (j == N * G) ? 1 : 0);
         chk("sc_moves_left", ml_o[j], N - fires);
         if (j >= 1 && j <= N * G - 1) begin
            chk("sc_row_column", rc_o[j], mv_rc[(j - 1) / G]);
            chk("sc_nrow", nr_o[j], mv_nr[(j - 1) / G]);
         end
         if (j == N * G) chk("sc_done_rc", rc_o[j], 0);
      end
   endtask

   initial begin
      vec[0] = '{4'b0100, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b1};
      vec[1] = '{4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0};
      vec[2] = '{4'b0001, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0};
      vec[3] = '{4'b1000, 1'b0, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b1};
      vec[4] = '{4'b0011, 1'b1, 1'b0, 1'b1, 4'b0011, 1'b1, 1'b0};
      vec[5] = '{4'b0010, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b1};
      reset = 1'b0; start = 1'b0; rand_in = '0; user_row_column = '0;
      user_nRow = 1'b0; user_fire = 1'b0; user_error = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rc", int'(row_column), 0);
      chk("rst_nrow", int'(x_nRow), 0);
      chk("rst_fire", int'(fire), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_moves_left", int'(moves_left), 0);
      @(negedge clk);
      reset = 1'b1;
      foreach (vec[i]) begin
         @(negedge clk);
         user_row_column = vec[i].urc; user_nRow = vec[i].unr;
         user_fire = vec[i].uf; user_error = vec[i].ue;
         @(posedge clk);
         #1;
         chk("pt_rc", int'(row_column), int'(vec[i].rc));
         chk("pt_nrow", int'(x_nRow), int'(vec[i].nr));
         chk("pt_fire", int'(fire), int'(vec[i].f));
         chk("pt_busy", int'(busy), 0);
      end
      for (int i = 0; i < 16; i++) begin
         logic [3:0] rc;
         logic nr, f, e;
         @(negedge clk);
         rc = 4'($urandom); nr = 1'($urandom); f = 1'($urandom); e = 1'($urandom);
         user_row_column = rc; user_nRow = nr; user_fire = f; user_error = e;
         @(posedge clk);
         #1;
         chk("rpt_rc", int'(row_column), int'(rc));
         chk("rpt_nrow", int'(x_nRow), int'(nr));
         chk("rpt_fire", int'(fire), (f && !e) ? 1 : 0);
      end
      @(negedge clk);
      user_fire = 1'b0;
      scramble(1'b1, 1'b0, 1'b0);
      scramble(1'b0, 1'b1, 1'b1);
      scramble(1'b0, 1'b0, 1'b0);
      // abort during the gap after the second fire
      @(negedge clk);
      start = 1'b1;
      rand_in = 3'($urandom);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (G + 2) @(posedge clk);
      #1;
      chk("ab_pre_moves_left", int'(moves_left), N - 2);
      chk("ab_pre_busy", int'(busy), 1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("ab_fire", int'(fire), 0);
      chk("ab_busy", int'(busy), 0);
      chk("ab_moves_left", int'(moves_left), 0);
      chk("ab_rc", int'(row_column), 0);
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("ab_done", int'(done), 0);
      end
      @(negedge clk);
      reset = 1'b1;
      last = 0;
      @(negedge clk);
      user_row_column = 4'b0001; user_nRow = 1'b1; user_fire = 1'b1; user_error = 1'b0;
      @(posedge clk);
      #1;
      chk("ab_pt_rc", int'(row_column), 1);
      chk("ab_pt_fire", int'(fire), 1);
      chk("ab_pt_busy", int'(busy), 0);
      chk("ab_pt_done", int'(done), 0);
      @(negedge clk);
      user_fire = 1'b0;
      scramble(1'b1, 1'b0, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
